uap_uart_rx: RTL

UAP_UART_RX -- requirements
Module: uap_uart_rx

---
 rtl/uap_uart_rx_if.sv | 33 +++
 rtl/uap_uart_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uap_uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module  : uap_uart_rx_if
// Brief   : Received-byte stream plus status pulses of the UART receiver.
// Revision: 1.0 - initial release
// ============================================================================
interface uap_uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overflow;
  logic       rx_parity_err;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    output rx_overflow,
    output rx_parity_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_frame_err,
    input  rx_overflow,
    input  rx_parity_err,
    output rx_ready
  );
endinterface
`default_nettype wire

// File: rtl/uap_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uap_uart_rx
// Brief   : Oversampling UART receiver (8N1, or 8E1 with UAP_UART_RX_PARITY_EN)
//           feeding a small ready/valid byte FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module uap_uart_rx #(
  parameter int BIT_CYCLES = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic     clk,
  input  wire logic     aresetn,
  input  wire logic     uart_rx,
  uap_uart_rx_if.master rx_if
);

  localparam int c_CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int c_AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_PTR_W = c_AW + 1;
  localparam logic [c_CNT_W-1:0] c_HALF = c_CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(BIT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

`ifdef UAP_UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  // ---------------------------------------------------------------- sync
  logic [1:0] sync_q;
  logic       prev_q;
  logic       line_w;

  assign line_w = sync_q[1];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], uart_rx};
      prev_q <= line_w;
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t             state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               frame_err_q, frame_err_d;
  logic               par_err_q, par_err_d;
  logic               par_bad_q, par_bad_d;
  logic               push_w;
  logic               cnt_zero_w;

  assign cnt_zero_w = (cnt_q == '0);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      par_bad_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      par_err_q   <= par_err_d;
      par_bad_q   <= par_bad_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    par_bad_d   = par_bad_q;
    frame_err_d = 1'b0;
    par_err_d   = 1'b0;
    push_w      = 1'b0;

    // Every non-idle state counts down and acts only on the terminal count,
    // so the counter is reloaded before it could wrap.
    if (state_q != S_IDLE && !cnt_zero_w) begin
      cnt_d = cnt_q - c_ONE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (prev_q && !line_w) begin
            state_d   = S_START;
            cnt_d     = c_HALF;
            par_bad_d = 1'b0;
          end
        end
        S_START: begin
          if (!line_w) begin
            state_d = S_DATA;
            cnt_d   = c_FULL;
            idx_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DATA: begin
          shift_d = {line_w, shift_q[7:1]};
          cnt_d   = c_FULL;
          if (idx_q == 3'd7) begin
`ifdef UAP_UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
`ifdef UAP_UART_RX_PARITY_EN
        S_PARITY: begin
          par_bad_d = line_w ^ (^shift_q);
          cnt_d     = c_FULL;
          state_d   = S_STOP;
        end
`endif
        S_STOP: begin
          state_d     = S_IDLE;
          frame_err_d = !line_w;
          par_err_d   = par_bad_q;
          push_w      = line_w && !par_bad_q;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0] wr_q, rd_q;
  logic               ovf_q;
  logic               empty_w, full_w, pop_w, wr_en_w;

  assign empty_w = (wr_q == rd_q);
  assign full_w  = (wr_q[c_PTR_W-1] != rd_q[c_PTR_W-1]) &&
                   (wr_q[c_AW-1:0] == rd_q[c_AW-1:0]);
  assign pop_w   = !empty_w && rx_if.rx_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign wr_en_w = push_w && (!full_w || pop_w);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      ovf_q <= push_w && !wr_en_w;
      if (wr_en_w) begin
        mem_q[wr_q[c_AW-1:0]] <= shift_q;
        wr_q                  <= wr_q + c_PTR_W'(1);
      end
      if (pop_w) begin
        rd_q <= rd_q + c_PTR_W'(1);
      end
    end
  end

  assign rx_if.rx_valid     = !empty_w;
  assign rx_if.rx_data      = empty_w ? 8'h00 : mem_q[rd_q[c_AW-1:0]];
  assign rx_if.rx_frame_err = frame_err_q;
  assign rx_if.rx_overflow  = ovf_q;
`ifdef UAP_UART_RX_PARITY_EN
  assign rx_if.rx_parity_err = par_err_q;
`else
  assign rx_if.rx_parity_err = 1'b0;
`endif

endmodule
`default_nettype wire
